// File: rtl/inst_sram_bridge.sv
// Fetch-side bridge: takes a one-cycle fetch call, translates kseg0/kseg1 PCs,
// runs one SRAM-like read at a time and returns the word with a one-cycle pulse.
module inst_sram_bridge #(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF,
  parameter int          TRANSLATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        call_begin,
  input  logic [31:0] fetch_addr,
  output logic        return_ready,
  output logic [31:0] return_instruction,
  output logic        fetch_adel,
  output logic        busy,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_capture;
  logic [31:0] w_data_next;
  logic        w_adel_next;
  logic [31:0] r_data;
  logic        r_adel;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_busy;
  logic        r_ret_ready;
  logic [31:0] r_ret_instr;
  logic        r_ret_adel;

  function automatic logic [31:0] f_translate(input logic [31:0] a);
    logic [31:0] res;
    if ((TRANSLATE != 0) && ((a[31:29] == 3'b100) || (a[31:29] == 3'b101))) begin
      res = a & PHYS_MASK;
    end else begin
      res = a;
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the RESP state is the cycle the return pulse is visible
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (call_begin && enable) begin
          w_accept = 1'b1;
          if (fetch_addr[1:0] == 2'b00) begin
            w_next = S_REQ;
          end else begin
            w_next = S_RESP;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (inst_addr_ok) begin
          if (inst_data_ok) begin
            w_capture = 1'b1;
            w_next    = enable ? S_RESP : S_HOLD;
          end else begin
            w_next = S_WAIT;
          end
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          w_capture = 1'b1;
          w_next    = enable ? S_RESP : S_HOLD;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_HOLD: begin
        w_next = enable ? S_RESP : S_HOLD;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Captured word and address-error flag; both clear once the pulse has gone out
  always_comb begin
    w_data_next = r_data;
    w_adel_next = r_adel;
    if (w_capture) begin
      w_data_next = inst_rdata;
    end else if (w_accept) begin
      w_data_next = 32'h0000_0000;
      w_adel_next = (fetch_addr[1:0] != 2'b00);
    end else if (r_state == S_RESP) begin
      w_data_next = 32'h0000_0000;
      w_adel_next = 1'b0;
    end else begin
      w_data_next = r_data;
      w_adel_next = r_adel;
    end
  end

  // Datapath and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= 32'h0000_0000;
      r_adel      <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_ret_ready <= 1'b0;
      r_ret_instr <= 32'h0000_0000;
      r_ret_adel  <= 1'b0;
    end else begin
      r_data      <= w_data_next;
      r_adel      <= w_adel_next;
      if (w_accept) begin
        r_addr <= f_translate(fetch_addr);
      end
      r_req       <= (w_next == S_REQ);
      r_busy      <= (w_next != S_IDLE);
      r_ret_ready <= (w_next == S_RESP);
      r_ret_instr <= (w_next == S_RESP) ? w_data_next : 32'h0000_0000;
      r_ret_adel  <= (w_next == S_RESP) ? w_adel_next : 1'b0;
    end
  end

  assign return_ready       = r_ret_ready;
  assign return_instruction = r_ret_instr;
  assign fetch_adel         = r_ret_adel;
  assign busy               = r_busy;
  assign inst_req           = r_req;
  assign inst_addr          = r_addr;
  assign inst_wr            = 1'b0;
  assign inst_size          = 2'b10;
  assign inst_wdata         = 32'h0000_0000;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Directed bench for inst_sram_bridge: stimulus and expected outputs are tabulated
// per cycle from fetch descriptions, then compared against the DUT every cycle.
module tb_inst_sram_bridge;
  localparam int N = 90;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        call_begin = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;

  logic        return_ready, fetch_adel, busy, inst_req, inst_wr;
  logic [31:0] return_instruction, inst_addr, inst_wdata;
  logic [1:0]  inst_size;
  logic        nt_ready, nt_adel, nt_busy, nt_req, nt_wr;
  logic [31:0] nt_instr, nt_addr, nt_wdata;
  logic [1:0]  nt_size;

  inst_sram_bridge #(.PHYS_MASK(32'h1FFF_FFFF), .TRANSLATE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .call_begin(call_begin),
    .fetch_addr(fetch_addr), .return_ready(return_ready),
    .return_instruction(return_instruction), .fetch_adel(fetch_adel), .busy(busy),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  inst_sram_bridge #(.PHYS_MASK(32'h1FFF_FFFF), .TRANSLATE(0)) dut_nt (
    .clk(clk), .reset(reset), .enable(enable), .call_begin(call_begin),
    .fetch_addr(fetch_addr), .return_ready(nt_ready),
    .return_instruction(nt_instr), .fetch_adel(nt_adel), .busy(nt_busy),
    .inst_req(nt_req), .inst_wr(nt_wr), .inst_size(nt_size),
    .inst_addr(nt_addr), .inst_wdata(nt_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  // Stimulus tables: entry n is driven during cycle n and sampled at edge n
  logic        t_rst[N], t_en[N], t_call[N], t_aok[N], t_dok[N];
  logic [31:0] t_faddr[N], t_rdata[N];
  // Expected outputs visible during cycle n (produced by edge n-1)
  logic        e_req[N], e_ready[N], e_adel[N], e_busy[N];
  logic [31:0] e_instr[N], e_addr[N], e_raw[N];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  function automatic logic [31:0] tr(input logic [31:0] a);
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Fetch at cycle c; addr_ok comes aw cycles after inst_req rises, data_ok in cycle d.
  // Enable table must already hold any stall for this fetch.
  task automatic fetch(input int c, input logic [31:0] a, input int aw, input int d,
                       input logic [31:0] data);
    int ac;
    int e;
    int r;
    t_call[c]  = 1'b1;
    t_faddr[c] = a;
    if (a[1:0] != 2'b00) begin
      e_ready[c+1] = 1'b1;
      e_adel[c+1]  = 1'b1;
      e_busy[c+1]  = 1'b1;
    end else begin
      ac = c + 1 + aw;
      for (int i = c + 1; i <= ac; i++) begin
        e_req[i]  = 1'b1;
        e_addr[i] = tr(a);
        e_raw[i]  = a;
      end
      t_aok[ac]  = 1'b1;
      t_dok[d]   = 1'b1;
      t_rdata[d] = data;
      e = d;
      while (e < N - 2 && !t_en[e]) e++;
      r = e + 1;
      for (int i = c + 1; i <= r; i++) e_busy[i] = 1'b1;
      e_ready[r] = 1'b1;
      e_instr[r] = data;
    end
  endtask

  // Fetch accepted with immediate addr_ok, then abandoned by reset in cycle x
  task automatic abandon(input int c, input logic [31:0] a, input int x);
    t_call[c]    = 1'b1;
    t_faddr[c]   = a;
    t_aok[c+1]   = 1'b1;
    e_req[c+1]   = 1'b1;
    e_addr[c+1]  = tr(a);
    e_raw[c+1]   = a;
    for (int i = c + 1; i <= x; i++) e_busy[i] = 1'b1;
    t_rst[x]     = 1'b1;
  endtask

  // Per-cycle comparison against the tables, plus literal pins for key cycles
  always @(negedge clk) begin
    if (k >= 1 && k < N) begin
      chk("return_ready", {31'b0, return_ready}, {31'b0, e_ready[k]});
      chk("return_instruction", return_instruction, e_instr[k]);
      chk("fetch_adel", {31'b0, fetch_adel}, {31'b0, e_adel[k]});
      chk("busy", {31'b0, busy}, {31'b0, e_busy[k]});
      chk("inst_req", {31'b0, inst_req}, {31'b0, e_req[k]});
      chk("nt_req", {31'b0, nt_req}, {31'b0, e_req[k]});
      chk("nt_ready", {31'b0, nt_ready}, {31'b0, e_ready[k]});
      chk("tie_wr", {31'b0, inst_wr}, 32'h0);
      chk("tie_size", {30'b0, inst_size}, 32'h2);
      chk("tie_wdata", inst_wdata, 32'h0);
      if (e_req[k]) begin
        chk("inst_addr", inst_addr, e_addr[k]);
        chk("nt_addr", nt_addr, e_raw[k]);
      end
      if (k == 1 || k == 71) chk("pin_addr_reset", inst_addr, 32'h0000_0000);
      if (k == 6)  chk("pin_kseg1_addr", inst_addr, 32'h1FC0_0000);
      if (k == 9)  chk("pin_t1_word", return_instruction, 32'h3C08_BFC0);
      if (k == 9)  chk("pin_t1_ready", {31'b0, return_ready}, 32'h1);
      if (k == 33) chk("pin_stall_word", return_instruction, 32'hCAFE_0001);
      if (k == 39) chk("pin_adel", {31'b0, fetch_adel}, 32'h1);
      if (k == 51) chk("pin_kuseg_addr", inst_addr, 32'h0040_0000);
      if (k == 61) chk("pin_nt_addr", nt_addr, 32'h8000_1000);
      if (k == 71) chk("pin_busy_reset", {31'b0, busy}, 32'h0);
    end
    k++;
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      t_rst[i] = (i < 3); t_en[i] = 1'b1; t_call[i] = 1'b0; t_aok[i] = 1'b0;
      t_dok[i] = 1'b0; t_faddr[i] = 32'h0; t_rdata[i] = 32'hEE00_0000 | 32'(i);
      e_req[i] = 1'b0; e_ready[i] = 1'b0; e_adel[i] = 1'b0; e_busy[i] = 1'b0;
      e_instr[i] = 32'h0; e_addr[i] = 32'h0; e_raw[i] = 32'h0;
    end
    for (int i = 29; i <= 31; i++) t_en[i] = 1'b0;
    t_en[42] = 1'b0;

    fetch(5,  32'hBFC0_0000, 0, 8,  32'h3C08_BFC0);
    fetch(14, 32'h9FC0_0010, 4, 21, 32'h1234_5678);
    fetch(26, 32'hBFC0_0020, 0, 29, 32'hCAFE_0001);
    fetch(38, 32'hBFC0_0002, 0, 0,  32'h0);
    t_call[42] = 1'b1; t_faddr[42] = 32'h0040_0000;
    fetch(45, 32'hBFC0_0100, 0, 46, 32'hDEAD_BEEF);
    fetch(50, 32'h0040_0000, 1, 55, 32'h0BAD_F00D);
    t_call[53] = 1'b1; t_faddr[53] = 32'h8000_1000;
    fetch(60, 32'h8000_1000, 0, 62, 32'h1111_2222);
    abandon(67, 32'hBFC0_0200, 70);
    fetch(73, 32'hBFC0_0300, 0, 75, 32'h5555_AAAA);
    fetch(77, 32'h0000_0004, 0, 78, 32'h7777_0000);

    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      reset        = t_rst[n];
      enable       = t_en[n];
      call_begin   = t_call[n];
      fetch_addr   = t_faddr[n];
      inst_addr_ok = t_aok[n];
      inst_data_ok = t_dok[n];
      inst_rdata   = t_rdata[n];
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
